// File: rtl/alu_instr_encoder.sv
// ALU request to RV32I instruction encoder with an output FIFO that feeds
// sequential instruction-memory writes starting at base_addr.
module alu_instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [31:0] base_addr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_ctrl,
    input  logic        req_imm_sel,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [11:0] req_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic          live_q;
    logic          err_q, err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal;
    logic [31:0] enc;
    logic        accept, push, pop;

    always_comb begin
        legal  = 1'b1;
        funct3 = 3'b000;
        funct7 = 7'b0000000;
        case (req_ctrl)
            3'b000: funct3 = 3'b000;
            3'b001: begin
                funct7 = 7'b0100000;
                legal  = ~req_imm_sel;
            end
            3'b010: funct3 = 3'b111;
            3'b011: funct3 = 3'b110;
            3'b101: funct3 = 3'b010;
            default: legal = 1'b0;
        endcase
        if (req_imm_sel)
            enc = {req_imm, req_rs1, funct3, req_rd, 7'b0010011};
        else
            enc = {funct7, req_rs2, req_rs1, funct3, req_rd, 7'b0110011};
    end

    // live_q is cleared asynchronously by reset, so the first edge after
    // release samples base_addr and only then opens req_ready.
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready & ~clear;
    assign req_ready = live_q & ~clear & ((count_q != FULL) | (out_valid & out_ready));
    assign accept    = req_valid & req_ready;
    assign push      = accept & legal;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_addr  = live_q ? addr_q : base_addr;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        if (!live_q || clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            addr_d    = base_addr;
            err_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                addr_d   = addr_q + 32'd4;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (accept && !legal) begin
                err_d = 1'b1;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            live_q    <= 1'b1;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= enc;
    end

endmodule

// File: doc/alu_instr_encoder.md
ALU_INSTR_ENCODER -- requirements
Module: alu_instr_encoder

Interface
REQ-001 Parameter: DEPTH, 4, output FIFO entries (power of two, >=2).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 clear  in  1  synchronous flush: empty FIFO, reload address, zero error count.
REQ-005 base_addr  in  32  instruction-memory start address, sampled on reset release and on clear.
REQ-006 req_valid / req_ready  in / out  1 / 1  request handshake; transfer when both high on a clock edge.
REQ-007 req_ctrl  in  3  ALU control code: 000 add, 001 sub, 010 and, 011 or, 101 slt; others illegal.
REQ-008 req_imm_sel  in  1  1 = I-type (immediate), 0 = R-type.
REQ-009 req_rd, req_rs1, req_rs2  in  5 each  register fields (req_rs2 ignored when req_imm_sel=1).
REQ-010 req_imm  in  12  immediate, used when req_imm_sel=1.
REQ-011 out_valid / out_ready  out / in  1 / 1  instruction-memory write handshake.
REQ-012 out_addr  out  32  byte address of the word at FIFO head.
REQ-013 out_data  out  32  encoded RV32I instruction word at FIFO head.
REQ-014 err  out  1  one-cycle pulse for each dropped illegal request.
REQ-015 err_cnt  out  8  count of dropped requests, saturates at 255.

Function
REQ-016 R-type word SHALL be {funct7, rs2, rs1, funct3, rd, 7'b0110011}; I-type word SHALL be {imm[11:0], rs1, funct3, rd, 7'b0010011}.
REQ-017 funct3 mapping SHALL be add/sub 000, slt 010, or 110, and 111; funct7 SHALL be 0100000 for sub, 0000000 otherwise.
REQ-018 Illegal requests (req_ctrl in {100,110,111}, or sub with req_imm_sel=1) SHALL be handshaken, not written to the FIFO, and SHALL raise err the following cycle and increment err_cnt (saturating).
REQ-019 Encoding SHALL be registered into the FIFO at the accepting edge; earliest out_valid is the cycle after acceptance (latency 1).
REQ-020 req_ready SHALL be high when FIFO count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle (out_valid & out_ready).
REQ-021 out_valid SHALL equal (count != 0); out_data SHALL be the oldest entry; entries leave in acceptance order.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-023 out_addr SHALL increment by 4 on every output handshake and wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-024 out_data and out_addr SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 clear SHALL take priority over concurrent push/pop: accepted request in that cycle is discarded, count=0, out_addr=base_addr, err_cnt=0, err=0 next cycle.
REQ-026 req_ready SHALL be low during a clear cycle.

Reset
REQ-027 While rst_n=0: count=0, out_valid=0, req_ready=0, err=0, err_cnt=0, out_data=0, out_addr=base_addr.
REQ-028 Reset asserted mid-transfer SHALL discard all FIFO contents immediately; no write completes after assertion.
REQ-029 req_ready SHALL rise no earlier than the first clock edge after rst_n deasserts.

Verification
REQ-030 base_addr=0x00000100; push add rd=3 rs1=1 rs2=2 -> next cycle out_valid=1, out_data=0x002081B3, out_addr=0x00000100; pop -> out_addr=0x00000104.
REQ-031 Push sub rd=5 rs1=6 rs2=7 then I-type add rd=1 rs1=0 imm=5 -> out words 0x407302B3 then 0x00500093 in order.
REQ-032 out_ready=0, push DEPTH+1 requests -> req_ready low after 4 accepted; with count=4 assert out_ready -> push and pop same cycle, count stays 4.
REQ-033 Push req_ctrl=111, then sub with imm_sel=1 -> err pulses twice, err_cnt=2, FIFO empty; 256 illegal pushes -> err_cnt=255.
REQ-034 FIFO holding 3 entries, assert clear with concurrent valid push -> next cycle out_valid=0, out_addr=base_addr, err_cnt=0.
REQ-035 base_addr=0xFFFFFFFC, two pops -> out_addr 0xFFFFFFFC then 0x00000000; rst_n low mid-burst -> out_valid=0 asynchronously.
